// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-skip adder/subtractor with valid/ready flow control
module csa_pipe_adder #(
  parameter int WIDTH        = 32,
  parameter int BLOCK        = 8,
  parameter int STAGE_BLOCKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int L    = NBLK / STAGE_BLOCKS;
  localparam int SW   = STAGE_BLOCKS * BLOCK;

  if (WIDTH % BLOCK != 0 || NBLK % STAGE_BLOCKS != 0) begin : g_bad
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK and NBLK a multiple of STAGE_BLOCKS");
  end

  logic [L-1:0] v;
  logic [L-1:0] adv;

  // a stage may load when it is empty or any later stage (or the consumer) frees a slot
  always_comb begin
    adv = ~v | {L{out_ready}};
    for (int s = 1; s < L; s++) adv = adv | (~v >> s);
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < L; k++) begin : g_s
    localparam int RW = WIDTH - k * SW;
    localparam int DW = (k + 1) * SW;
    logic          v_i, c_i, co, v_q, v_d, c_q, c_d;
    logic [RW-1:0] a_i, b_i;
    logic [SW-1:0] sw;
    logic [DW-1:0] s_q, s_d;

    assign v[k] = v_q;

    if (k == 0) begin : g_src
      // stage 0 takes operands from the ports, inverting B and forcing carry-in for subtract
      always_comb begin
        v_i = in_valid;
        a_i = in_a;
        b_i = in_sub ? ~in_b : in_b;
        c_i = in_sub | in_cin;
      end
      // first sum slice starts the accumulated result
      always_comb s_d = adv[k] ? sw : s_q;
    end else begin : g_src
      // later stages consume the remaining slices and carry registered by the previous stage
      always_comb begin
        v_i = g_s[k-1].v_q;
        a_i = g_s[k-1].g_ab.a_q;
        b_i = g_s[k-1].g_ab.b_q;
        c_i = g_s[k-1].c_q;
      end
      // append this stage's slice above the bits already produced
      always_comb s_d = adv[k] ? {sw, g_s[k-1].s_q} : s_q;
    end

    // ripple each block, then skip its carry straight through when every bit propagates
    always_comb begin
      logic [SW-1:0]    aw, bw;
      logic [BLOCK-1:0] ta, tb, ts;
      logic             rc;
      aw = a_i[SW-1:0];
      bw = b_i[SW-1:0];
      sw = '0;
      co = c_i;
      ta = '0;
      tb = '0;
      ts = '0;
      rc = 1'b0;
      for (int j = 0; j < STAGE_BLOCKS; j++) begin
        ta = aw[BLOCK-1:0];
        tb = bw[BLOCK-1:0];
        {rc, ts} = {1'b0, ta} + {1'b0, tb} + {{BLOCK{1'b0}}, co};
        co = &(ta ^ tb) ? co : rc;
        sw = (sw >> BLOCK) | (SW'(ts) << (SW - BLOCK));
        aw = aw >> BLOCK;
        bw = bw >> BLOCK;
      end
    end

    // load from upstream when advancing, otherwise hold
    always_comb begin
      v_d = adv[k] ? v_i : v_q;
      c_d = adv[k] ? co : c_q;
    end

    // stage control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < L - 1) begin : g_ab
      logic [RW-SW-1:0] a_q, a_d, b_q, b_d;
      // forward only the operand slices later stages still need
      always_comb begin
        a_d = adv[k] ? a_i[RW-1:SW] : a_q;
        b_d = adv[k] ? b_i[RW-1:SW] : b_q;
      end
      // remaining operand registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == L - 1) begin : g_o
      logic o_q, o_d;
      // carry into the MSB is recovered from the MSB sum bit; overflow is it xor carry out
      always_comb o_d = adv[k] ? (sw[SW-1] ^ a_i[SW-1] ^ b_i[SW-1] ^ co) : o_q;
      // overflow register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_q <= 1'b0;
        else        o_q <= o_d;
      end
    end
  end

  assign out_valid = g_s[L-1].v_q;
  assign out_sum   = g_s[L-1].s_q;
  assign out_cout  = g_s[L-1].c_q;
  assign out_ovf   = g_s[L-1].g_o.o_q;
endmodule
